filter_input_generator: RTL and testbench
=========================================

FILTER_INPUT_GENERATOR -- requirements
Module: filter_input_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one IEEE-754 single coordinate.
REQ-002 Parameter NUM_FILTER, default 4, number of filter lanes fed.
REQ-003 Parameter PARTICLE_ID_WIDTH, default 7, particle index width within one cell (max 128 particles).
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to generate all pairs for one cell pair.
REQ-007 same_cell  in  1  home and neighbour are the same cell; sampled with start.
REQ-008 home_count, nbr_count  in  PARTICLE_ID_WIDTH+1 each  particle counts; sampled with start.
REQ-009 ref_rd_addr, nbr_rd_addr  out  PARTICLE_ID_WIDTH each  read addresses to home/neighbour position memories.
REQ-010 ref_rd_data, nbr_rd_data  in  3*DATA_WIDTH each  {z,y,x} positions, valid exactly 1 cycle after address.
REQ-011 back_pressure  in  NUM_FILTER  per-lane stop request from the filter bank.
REQ-012 input_valid  out  NUM_FILTER  one-cycle per-lane pair strobe.
REQ-013 refx, refy, refz, neighborx, neighbory, neighborz  out  NUM_FILTER*DATA_WIDTH each  lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-014 busy  out  1  high from the cycle after start is accepted until done.
REQ-015 done  out  1  one-cycle pulse when the last pair has been presented.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on start, ISSUE->DRAIN after last pair issued, DRAIN->DONE when no pair in flight, DONE->IDLE unconditionally after one cycle (done=1 in DONE).
REQ-017 start SHALL be ignored unless in IDLE.
REQ-018 Pair order SHALL be ref index outer loop, neighbour index inner loop, both ascending from 0.
REQ-019 With same_cell=0 every (r,n), r<home_count, n<nbr_count, SHALL be issued; with same_cell=1 only n>r (nbr_count ignored, home_count used for both).
REQ-020 If the pair set is empty (any count 0, or same_cell with home_count<=1), the FSM SHALL go IDLE->DONE directly, no input_valid.
REQ-021 A round-robin lane pointer (reset 0) SHALL select the target lane each ISSUE cycle; if back_pressure of that lane is 0 the pair issues, else no issue; the pointer advances by one (mod NUM_FILTER) every ISSUE cycle either way.
REQ-022 back_pressure SHALL be checked only at issue; pairs in flight (max 2) SHALL always be delivered.
REQ-023 Latency: addresses registered in the issue cycle; data captured 1 cycle later; lane outputs and input_valid registered the cycle after -- input_valid rises 3 cycles after the start cycle for an unpressured first lane.
REQ-024 Lane data outputs SHALL hold their last value until that lane's next pair; at most one input_valid bit high per cycle.
REQ-025 done SHALL be asserted in the cycle immediately after the last input_valid.

Reset
REQ-026 On rst low, asynchronously: state IDLE, lane pointer 0, indices 0, input_valid 0, busy 0, done 0, addresses 0, lane data 0; in-flight pairs discarded.
REQ-027 Reset mid-operation SHALL produce no further input_valid or done for the aborted request.

Structure
REQ-028 FSM state encoding and the pair-counter width SHALL live in the shared MD package.
REQ-029 The index stepping (outer/inner counters, same_cell start, end detection) SHALL be one sub-module, pair_index_counter.

Verification
REQ-030 home=2, nbr=3, same_cell=0, no pressure, NUM_FILTER=4 -> pairs (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) on lanes 0,1,2,3,0,1, valids in cycles 3..8 after start, done in cycle 9.
REQ-031 home=4, same_cell=1 -> six pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3), correct coordinates from memory model.
REQ-032 home=1, same_cell=1 -> no input_valid, done pulse, back to IDLE.
REQ-033 back_pressure[1] held high, home=1, nbr=4 -> pairs on lanes 0,2,3,0 with one bubble per skipped lane 1; lane 1 never strobed.
REQ-034 rst low for one cycle after the 2nd pair of a 3x3 run -> all outputs 0 immediately, no further valid/done; a new start then completes normally.
REQ-035 start pulsed while busy -> ignored, pair count of the original request unchanged.

Source files
------------

// File: rtl/filter_input_generator_pkg.sv
// Shared definitions for the filter input generator: FSM encoding and counter widths.
package filter_input_generator_pkg;

  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_ISSUE = 2'd1;
  localparam fsm_state_t ST_DRAIN = 2'd2;
  localparam fsm_state_t ST_DONE  = 2'd3;

  // Particle counts need one bit more than an index so a full cell (2**id_width) fits.
  function automatic int unsigned pair_cnt_width(input int unsigned id_width);
    return id_width + 1;
  endfunction

  function automatic int unsigned lane_ptr_width(input int unsigned num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/pair_index_counter.sv
// Steps (ref, neighbour) index pairs in ref-outer / neighbour-inner order and
// flags the last pair; in same-cell mode only pairs with neighbour > ref are produced.
module pair_index_counter
  import filter_input_generator_pkg::*;
#(
  parameter int unsigned PARTICLE_ID_WIDTH = 7,
  localparam int unsigned CNT_W = pair_cnt_width(PARTICLE_ID_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         step,
  input  logic                         same_cell,
  input  logic [CNT_W-1:0]             home_count,
  input  logic [CNT_W-1:0]             nbr_count,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_idx,
  output logic [PARTICLE_ID_WIDTH-1:0] nbr_idx,
  output logic                         empty,
  output logic                         last
);

  localparam logic [CNT_W-1:0]             CNT_ONE = CNT_W'(1);
  localparam logic [PARTICLE_ID_WIDTH-1:0] ID_ONE  = PARTICLE_ID_WIDTH'(1);
  localparam logic [PARTICLE_ID_WIDTH-1:0] ID_TWO  = PARTICLE_ID_WIDTH'(2);

  logic [PARTICLE_ID_WIDTH-1:0] ref_q, nbr_q;
  logic [CNT_W-1:0]             home_q, nbr_cnt_q;
  logic                         same_q;

  logic [CNT_W-1:0]             ref_inc, nbr_inc, nbr_lim, ref_lim;
  logic [PARTICLE_ID_WIDTH-1:0] ref_nxt, ref_nxt2, nbr_nxt;

  // Wide increments for end detection, index-wide ones for stepping.
  always_comb begin
    ref_inc  = {1'b0, ref_q} + CNT_ONE;
    nbr_inc  = {1'b0, nbr_q} + CNT_ONE;
    ref_nxt  = ref_q + ID_ONE;
    ref_nxt2 = ref_q + ID_TWO;
    nbr_nxt  = nbr_q + ID_ONE;
    nbr_lim  = same_q ? home_q : nbr_cnt_q;
    ref_lim  = same_q ? (home_q - CNT_ONE) : home_q;
    last     = (nbr_inc == nbr_lim) && (ref_inc == ref_lim);
    empty    = same_cell ? (home_count <= CNT_ONE)
                         : ((home_count == '0) || (nbr_count == '0));
  end

  // Index registers double as the memory read addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q     <= '0;
      nbr_q     <= '0;
      home_q    <= '0;
      nbr_cnt_q <= '0;
      same_q    <= 1'b0;
    end else if (load) begin
      ref_q     <= '0;
      nbr_q     <= same_cell ? ID_ONE : '0;
      home_q    <= home_count;
      nbr_cnt_q <= nbr_count;
      same_q    <= same_cell;
    end else if (step) begin
      if (nbr_inc < nbr_lim) begin
        nbr_q <= nbr_nxt;
      end else begin
        ref_q <= ref_nxt;
        nbr_q <= same_q ? ref_nxt2 : '0;
      end
    end
  end

  assign ref_idx = ref_q;
  assign nbr_idx = nbr_q;

endmodule

// File: rtl/filter_input_generator.sv
// Walks all particle pairs of a (home, neighbour) cell pair, reads both positions and
// hands each pair round-robin to one of NUM_FILTER filter lanes.
module filter_input_generator
  import filter_input_generator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned NUM_FILTER        = 4,
  parameter int unsigned PARTICLE_ID_WIDTH = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             same_cell,
  input  logic [PARTICLE_ID_WIDTH:0]       home_count,
  input  logic [PARTICLE_ID_WIDTH:0]       nbr_count,
  output logic [PARTICLE_ID_WIDTH-1:0]     ref_rd_addr,
  output logic [PARTICLE_ID_WIDTH-1:0]     nbr_rd_addr,
  input  logic [3*DATA_WIDTH-1:0]          ref_rd_data,
  input  logic [3*DATA_WIDTH-1:0]          nbr_rd_data,
  input  logic [NUM_FILTER-1:0]            back_pressure,
  output logic [NUM_FILTER-1:0]            input_valid,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] refx,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] refy,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] refz,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] neighborx,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] neighbory,
  output logic [NUM_FILTER*DATA_WIDTH-1:0] neighborz,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned LANE_W = lane_ptr_width(NUM_FILTER);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_FILTER - 1);
  localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);

  fsm_state_t        state_q, state_d;
  logic [LANE_W-1:0] lane_ptr_q;
  logic              p1_valid_q;
  logic [LANE_W-1:0] p1_lane_q;

  logic accept, issue, pair_empty, pair_last;

  assign accept = (state_q == ST_IDLE) && start;
  assign issue  = (state_q == ST_ISSUE) && !back_pressure[lane_ptr_q];

  pair_index_counter #(
    .PARTICLE_ID_WIDTH(PARTICLE_ID_WIDTH)
  ) u_pair_index_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (issue && !pair_last),
    .same_cell (same_cell),
    .home_count(home_count),
    .nbr_count (nbr_count),
    .ref_idx   (ref_rd_addr),
    .nbr_idx   (nbr_rd_addr),
    .empty     (pair_empty),
    .last      (pair_last)
  );

  // Next-state: DRAIN waits only on the address/data stage; the output stage is
  // already presenting its pair in the cycle DRAIN exits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = pair_empty ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (issue && pair_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!p1_valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state, round-robin lane pointer and the read-in-flight stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lane_ptr_q <= '0;
      p1_valid_q <= 1'b0;
      p1_lane_q  <= '0;
    end else begin
      state_q    <= state_d;
      p1_valid_q <= issue;
      p1_lane_q  <= lane_ptr_q;
      // Pointer moves every ISSUE cycle, so a pressured lane costs one bubble.
      if (state_q == ST_ISSUE) begin
        lane_ptr_q <= (lane_ptr_q == LANE_LAST) ? '0 : lane_ptr_q + LANE_ONE;
      end
    end
  end

  // Output stage: capture read data into the target lane; other lanes hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      input_valid <= '0;
      refx        <= '0;
      refy        <= '0;
      refz        <= '0;
      neighborx   <= '0;
      neighbory   <= '0;
      neighborz   <= '0;
    end else begin
      input_valid <= '0;
      if (p1_valid_q) begin
        input_valid[p1_lane_q]                         <= 1'b1;
        refx[p1_lane_q*DATA_WIDTH +: DATA_WIDTH]      <= ref_rd_data[0 +: DATA_WIDTH];
        refy[p1_lane_q*DATA_WIDTH +: DATA_WIDTH]      <= ref_rd_data[DATA_WIDTH +: DATA_WIDTH];
        refz[p1_lane_q*DATA_WIDTH +: DATA_WIDTH]      <= ref_rd_data[2*DATA_WIDTH +: DATA_WIDTH];
        neighborx[p1_lane_q*DATA_WIDTH +: DATA_WIDTH] <= nbr_rd_data[0 +: DATA_WIDTH];
        neighbory[p1_lane_q*DATA_WIDTH +: DATA_WIDTH] <= nbr_rd_data[DATA_WIDTH +: DATA_WIDTH];
        neighborz[p1_lane_q*DATA_WIDTH +: DATA_WIDTH] <= nbr_rd_data[2*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_filter_input_generator.sv
// Directed bench for filter_input_generator: scenario table plus abort sequence.
module tb_filter_input_generator;

  localparam int DW = 32;
  localparam int NF = 4;
  localparam int PW = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            same_cell = 1'b0;
  logic [PW:0]     home_count = '0;
  logic [PW:0]     nbr_count = '0;
  logic [PW-1:0]   ref_rd_addr, nbr_rd_addr;
  logic [3*DW-1:0] ref_rd_data = '0;
  logic [3*DW-1:0] nbr_rd_data = '0;
  logic [NF-1:0]   back_pressure = '0;
  logic [NF-1:0]   input_valid;
  logic [NF*DW-1:0] refx, refy, refz, neighborx, neighbory, neighborz;
  logic            busy, done;

  int checks = 0;
  int errors = 0;

  filter_input_generator #(
    .DATA_WIDTH       (DW),
    .NUM_FILTER       (NF),
    .PARTICLE_ID_WIDTH(PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .same_cell    (same_cell),
    .home_count   (home_count),
    .nbr_count    (nbr_count),
    .ref_rd_addr  (ref_rd_addr),
    .nbr_rd_addr  (nbr_rd_addr),
    .ref_rd_data  (ref_rd_data),
    .nbr_rd_data  (nbr_rd_data),
    .back_pressure(back_pressure),
    .input_valid  (input_valid),
    .refx         (refx),
    .refy         (refy),
    .refz         (refz),
    .neighborx    (neighborx),
    .neighbory    (neighbory),
    .neighborz    (neighborz),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [3*DW-1:0] ref_word(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {32'h3300_0000 | v, 32'h2200_0000 | v, 32'h1100_0000 | v};
  endfunction

  function automatic logic [3*DW-1:0] nbr_word(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {32'h6600_0000 | v, 32'h5500_0000 | v, 32'h4400_0000 | v};
  endfunction

  // Position memories: one cycle read latency.
  always @(posedge clk) begin
    ref_rd_data <= ref_word(int'(ref_rd_addr));
    nbr_rd_data <= nbr_word(int'(nbr_rd_addr));
  end

  typedef struct {
    int       home;
    int       nbr;
    bit       same;
    bit [3:0] bp;
    int       exp_pairs;
    int       exp_done;
    bit       restart;
  } scen_t;

  typedef struct {
    int cyc;
    int lane;
    int r;
    int n;
  } pair_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input scen_t s);
    pair_t           exp_q[$];
    pair_t           e;
    logic [3*DW-1:0] last_ref[NF];
    logic [3*DW-1:0] last_nbr[NF];
    int ptr, c, got, done_at, n_lo, n_hi;
    ptr = 0; c = 1; got = 0; done_at = -1;
    for (int l = 0; l < NF; l++) begin
      last_ref[l] = '0;
      last_nbr[l] = '0;
    end
    // Expected pair schedule: pointer steps every ISSUE cycle, pressured lanes skipped.
    for (int r = 0; r < s.home; r++) begin
      n_lo = s.same ? r + 1 : 0;
      n_hi = s.same ? s.home : s.nbr;
      for (int n = n_lo; n < n_hi; n++) begin
        while (s.bp[ptr]) begin
          ptr = (ptr + 1) % NF;
          c++;
        end
        e.cyc = c + 2; e.lane = ptr; e.r = r; e.n = n;
        exp_q.push_back(e);
        last_ref[ptr] = ref_word(r);
        last_nbr[ptr] = nbr_word(n);
        ptr = (ptr + 1) % NF;
        c++;
      end
    end
    same_cell     = s.same;
    home_count    = 8'(s.home);
    nbr_count     = 8'(s.nbr);
    back_pressure = s.bp;
    start         = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        check("busy_after_start", busy, (s.exp_pairs > 0));
      end
      if (input_valid != '0) begin
        check("valid_onehot", $countones(input_valid), 1);
        for (int l = 0; l < NF; l++) begin
          if (input_valid[l]) begin
            if (got < exp_q.size()) begin
              e = exp_q[got];
              check("valid_lane", l, e.lane);
              check("valid_cycle", cyc, e.cyc);
              check("ref_xyz", {refz[l*DW +: DW], refy[l*DW +: DW], refx[l*DW +: DW]},
                    ref_word(e.r));
              check("nbr_xyz", {neighborz[l*DW +: DW], neighbory[l*DW +: DW],
                                neighborx[l*DW +: DW]}, nbr_word(e.n));
            end else begin
              check("extra_valid", got, exp_q.size());
            end
            got++;
          end
        end
      end
      if (done) begin
        done_at = cyc;
        check("done_cycle", cyc, s.exp_done);
        check("pairs_at_done", got, s.exp_pairs);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);
        break;
      end
      if (s.restart && cyc == 2) begin
        start      = 1'b1;
        same_cell  = ~s.same;
        home_count = 8'd5;
        nbr_count  = 8'd5;
      end
      if (s.restart && cyc == 3) start = 1'b0;
    end
    if (done_at < 0) check("done_timeout", done_at, s.exp_done);
    // Every lane holds the last pair it was given (zero if never strobed).
    for (int l = 0; l < NF; l++) begin
      check("hold_ref", {refz[l*DW +: DW], refy[l*DW +: DW], refx[l*DW +: DW]}, last_ref[l]);
      check("hold_nbr", {neighborz[l*DW +: DW], neighbory[l*DW +: DW], neighborx[l*DW +: DW]},
            last_nbr[l]);
    end
    start         = 1'b0;
    back_pressure = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, input_valid, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_addr"}, {ref_rd_addr, nbr_rd_addr}, '0);
    check({tag, "_ref"}, refx | refy | refz, '0);
    check({tag, "_nbr"}, neighborx | neighbory | neighborz, '0);
  endtask

  scen_t tbl[10];

  initial begin
    int nval, bad;
    tbl[0] = '{2, 3, 1'b0, 4'b0000, 6, 9, 1'b0};
    tbl[1] = '{4, 7, 1'b1, 4'b0000, 6, 9, 1'b0};
    tbl[2] = '{1, 4, 1'b1, 4'b0000, 0, 1, 1'b0};
    tbl[3] = '{1, 4, 1'b0, 4'b0010, 4, 8, 1'b0};
    tbl[4] = '{0, 5, 1'b0, 4'b0000, 0, 1, 1'b0};
    tbl[5] = '{3, 1, 1'b0, 4'b0000, 3, 6, 1'b0};
    tbl[6] = '{2, 2, 1'b1, 4'b0000, 1, 4, 1'b0};
    tbl[7] = '{2, 3, 1'b0, 4'b0000, 6, 9, 1'b1};
    tbl[8] = '{3, 3, 1'b0, 4'b0000, 9, 12, 1'b0};
    tbl[9] = '{3, 1, 1'b0, 4'b1001, 3, 9, 1'b0};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run(tbl[i]);
    end

    // Abort a 3x3 run after its second pair; nothing more may come out of it.
    do_reset();
    same_cell = 1'b0; home_count = 8'd3; nbr_count = 8'd3; back_pressure = '0;
    start = 1'b1;
    nval = 0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (input_valid != '0) nval++;
    end
    check("pre_abort_valids", nval, 2);
    rst = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (input_valid != '0 || done || busy) bad++;
    end
    check("quiet_after_abort", bad, 0);
    run(tbl[8]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
